// File: rtl/bridge_read_mapper.sv
// Services APF bridge reads that fall inside an address window. It translates each
// hit into a handshaked target-memory read and returns the data on the bridge read bus.
module bridge_read_mapper #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h0,
  parameter logic [31:0] MAP_ADDRESS    = 32'h0,
  parameter logic [15:0] MAP_LENGTH     = 16'd0,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] DEFAULT_DATA   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] bridge_addr,
  input  logic        bridge_rd,
  output logic [31:0] bridge_rd_data,
  output logic        rd_done,
  output logic        rd_timeout,
  output logic        rd_dropped,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic        mem_rd_req,
  input  logic        mem_rd_ack,
  input  logic        mem_rd_data_valid,
  input  logic [31:0] mem_rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  // A window whose 32-bit end address wraps below its base selects nothing.
  localparam logic [32:0] END_FULL  = {1'b0, BASE_ADDRESS} + {17'h0, MAP_LENGTH};
  localparam logic        WINDOW_OK = ~END_FULL[32];

  state_t      state_reg, state_next;
  logic [15:0] count_reg, count_next;
  logic [31:0] data_next;
  logic [31:0] addr_next;
  logic        done_next, timeout_next, dropped_next;

  logic [31:0] window_len;
  logic [31:0] offset;
  logic [31:0] mapped_addr;
  logic        hit;
  logic        count_last;

  assign window_len  = {16'h0, MAP_LENGTH};
  assign offset      = bridge_addr - BASE_ADDRESS;
  assign mapped_addr = offset + MAP_ADDRESS;
  assign hit         = WINDOW_OK && (offset < window_len);
  assign count_last  = (count_reg == TIMEOUT_LAST);

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    data_next    = bridge_rd_data;
    addr_next    = mem_addr;
    done_next    = 1'b0;
    timeout_next = 1'b0;
    dropped_next = bridge_rd && hit && (state_reg != S_IDLE);

    unique case (state_reg)
      S_IDLE: begin
        if (bridge_rd && hit) begin
          addr_next  = mapped_addr;
          count_next = 16'd0;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        count_next = count_reg + 16'd1;
        if (mem_rd_ack && mem_rd_data_valid) begin
          data_next  = mem_rd_data;
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else if (count_last) begin
          data_next    = DEFAULT_DATA;
          done_next    = 1'b1;
          timeout_next = 1'b1;
          // An ack on the final cycle means a response may still arrive, so drain it.
          if (mem_rd_ack) begin
            count_next = 16'd0;
            state_next = S_DRAIN;
          end else begin
            state_next = S_IDLE;
          end
        end else if (mem_rd_ack) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        count_next = count_reg + 16'd1;
        if (mem_rd_data_valid) begin
          data_next  = mem_rd_data;
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else if (count_last) begin
          data_next    = DEFAULT_DATA;
          done_next    = 1'b1;
          timeout_next = 1'b1;
          count_next   = 16'd0;
          state_next   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        count_next = count_reg + 16'd1;
        if (mem_rd_data_valid || count_last) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      count_reg      <= 16'd0;
      bridge_rd_data <= 32'h0;
      mem_addr       <= 32'h0;
      mem_rd_req     <= 1'b0;
      rd_done        <= 1'b0;
      rd_timeout     <= 1'b0;
      rd_dropped     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      bridge_rd_data <= data_next;
      mem_addr       <= addr_next;
      mem_rd_req     <= (state_next == S_REQ);
      rd_done        <= done_next;
      rd_timeout     <= timeout_next;
      rd_dropped     <= dropped_next;
      busy           <= (state_next != S_IDLE);
    end
  end

endmodule

// File: tb/tb_bridge_read_mapper.sv
// Directed bench for bridge_read_mapper: table of single reads plus timeout, drain,
// dropped-request and mid-read reset sequences.
module tb_bridge_read_mapper;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] bridge_addr;
  logic        bridge_rd;
  logic [31:0] bridge_rd_data;
  logic        rd_done, rd_timeout, rd_dropped, busy;
  logic [31:0] mem_addr;
  logic        mem_rd_req;
  logic        mem_rd_ack;
  logic        mem_rd_data_valid;
  logic [31:0] mem_rd_data;

  always #5 clk = ~clk;

  bridge_read_mapper #(
    .BASE_ADDRESS  (32'h1000_0000),
    .MAP_ADDRESS   (32'h0020_0000),
    .MAP_LENGTH    (16'h0100),
    .TIMEOUT_CYCLES(16),
    .DEFAULT_DATA  (32'hFFFF_FFFF)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .bridge_addr      (bridge_addr),
    .bridge_rd        (bridge_rd),
    .bridge_rd_data   (bridge_rd_data),
    .rd_done          (rd_done),
    .rd_timeout       (rd_timeout),
    .rd_dropped       (rd_dropped),
    .busy             (busy),
    .mem_addr         (mem_addr),
    .mem_rd_req       (mem_rd_req),
    .mem_rd_ack       (mem_rd_ack),
    .mem_rd_data_valid(mem_rd_data_valid),
    .mem_rd_data      (mem_rd_data)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          gap;       // cycles from ack to valid; 0 = same cycle
    bit          hit;
    logic [31:0] exp_mem_addr;
  } vec_t;

  vec_t        vecs [6];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_data = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input int gap,
                         input bit hit, input logic [31:0] exp_addr);
    bridge_addr = addr;
    bridge_rd   = 1'b1;
    step();
    bridge_rd = 1'b0;
    check("req_after_rd", mem_rd_req, hit);
    check("busy_after_rd", busy, hit);
    if (hit) begin
      check("mem_addr", mem_addr, exp_addr);
      for (int c = 1; c <= 1 + gap; c++) begin
        mem_rd_ack        = (c == 1);
        mem_rd_data_valid = (c == 1 + gap);
        mem_rd_data       = (c == 1 + gap) ? data : 32'h5555_AAAA;
        check("req_level", mem_rd_req, (c == 1));
        check("no_early_done", rd_done, 0);
        step();
      end
      mem_rd_ack        = 1'b0;
      mem_rd_data_valid = 1'b0;
      exp_data          = data;
      check("done", rd_done, 1);
      check("no_timeout", rd_timeout, 0);
      check("rd_data", bridge_rd_data, exp_data);
      check("busy_fall", busy, 0);
      step();
      check("done_pulse", rd_done, 0);
    end else begin
      for (int c = 0; c < 3; c++) begin
        check("miss_no_done", rd_done, 0);
        check("miss_no_req", mem_rd_req, 0);
        check("miss_data_hold", bridge_rd_data, exp_data);
        step();
      end
    end
    $display("read addr=%h hit=%0d data=%h", addr, hit, bridge_rd_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h1000_0010, 32'hCAFE_F00D, 2, 1'b1, 32'h0020_0010};
    vecs[1] = '{32'h0FFF_FFFC, 32'h0,         0, 1'b0, 32'h0};
    vecs[2] = '{32'h1000_0100, 32'h0,         0, 1'b0, 32'h0};
    vecs[3] = '{32'h1000_00FC, 32'h1234_5678, 0, 1'b1, 32'h0020_00FC};
    vecs[4] = '{32'h1000_0000, 32'hA5A5_0001, 1, 1'b1, 32'h0020_0000};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0,         0, 1'b0, 32'h0};

    reset_n = 1'b0;
    bridge_addr = 32'h0;
    bridge_rd = 1'b0;
    mem_rd_ack = 1'b0;
    mem_rd_data_valid = 1'b0;
    mem_rd_data = 32'h0;
    step();
    step();
    check("rst_data", bridge_rd_data, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_req", mem_rd_req, 0);
    check("rst_done", rd_done, 0);
    check("rst_busy", busy, 0);
    check("rst_dropped", rd_dropped, 0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++)
      do_read(vecs[i].addr, vecs[i].data, vecs[i].gap, vecs[i].hit, vecs[i].exp_mem_addr);

    // Never acked: request held 16 cycles, then timeout straight to idle.
    bridge_addr = 32'h1000_0020;
    bridge_rd   = 1'b1;
    step();
    bridge_rd = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      check("noack_req", mem_rd_req, 1);
      check("noack_done", rd_done, 0);
      step();
    end
    exp_data = 32'hFFFF_FFFF;
    check("noack_done_pulse", rd_done, 1);
    check("noack_timeout", rd_timeout, 1);
    check("noack_data", bridge_rd_data, exp_data);
    check("noack_busy", busy, 0);
    check("noack_req_drop", mem_rd_req, 0);
    $display("timeout no-ack data=%h", bridge_rd_data);
    step();
    check("noack_timeout_pulse", rd_timeout, 0);

    // Acked, valid 20 cycles later: timeout, then drain absorbs the late response.
    bridge_addr = 32'h1000_0040;
    bridge_rd   = 1'b1;
    step();
    bridge_rd  = 1'b0;
    mem_rd_ack = 1'b1;
    step();
    mem_rd_ack = 1'b0;
    repeat (15) step();
    check("late_done", rd_done, 1);
    check("late_timeout", rd_timeout, 1);
    check("late_data", bridge_rd_data, 32'hFFFF_FFFF);
    check("late_busy_drain", busy, 1);
    for (int c = 18; c <= 21; c++) begin
      step();
      check("drain_busy", busy, 1);
    end
    mem_rd_data_valid = 1'b1;
    mem_rd_data       = 32'hDEAD_BEEF;
    step();
    mem_rd_data_valid = 1'b0;
    check("drain_exit", busy, 0);
    check("drain_no_done", rd_done, 0);
    check("drain_discard", bridge_rd_data, 32'hFFFF_FFFF);
    $display("late response drained data=%h", bridge_rd_data);
    do_read(32'h1000_0044, 32'h0BAD_CAFE, 0, 1'b1, 32'h0020_0044);

    // Second in-window read while busy is dropped; out-of-window one is silent.
    bridge_addr = 32'h1000_0050;
    bridge_rd   = 1'b1;
    step();
    bridge_addr = 32'h1000_0060;
    mem_rd_ack  = 1'b1;
    step();
    mem_rd_ack = 1'b0;
    check("dropped_pulse", rd_dropped, 1);
    check("dropped_addr_kept", mem_addr, 32'h0020_0050);
    bridge_addr       = 32'h2000_0000;
    mem_rd_data_valid = 1'b1;
    mem_rd_data       = 32'h1111_2222;
    step();
    bridge_rd         = 1'b0;
    mem_rd_data_valid = 1'b0;
    exp_data          = 32'h1111_2222;
    check("dropped_first_done", rd_done, 1);
    check("dropped_first_data", bridge_rd_data, exp_data);
    check("miss_busy_no_drop", rd_dropped, 0);
    step();
    check("dropped_not_started", mem_rd_req, 0);
    check("dropped_idle", busy, 0);
    $display("dropped sequence data=%h", bridge_rd_data);

    // Reset at cycle 2, late valid at cycle 3 must be ignored.
    bridge_addr = 32'h1000_0070;
    bridge_rd   = 1'b1;
    step();
    bridge_rd  = 1'b0;
    mem_rd_ack = 1'b1;
    step();
    mem_rd_ack = 1'b0;
    reset_n    = 1'b0;
    #1;
    exp_data = 32'h0;
    check("midrst_data", bridge_rd_data, exp_data);
    check("midrst_mem_addr", mem_addr, 32'h0);
    check("midrst_req", mem_rd_req, 0);
    check("midrst_busy", busy, 0);
    step();
    reset_n           = 1'b1;
    mem_rd_data_valid = 1'b1;
    mem_rd_data       = 32'h7777_7777;
    step();
    mem_rd_data_valid = 1'b0;
    check("postrst_no_done", rd_done, 0);
    check("postrst_data", bridge_rd_data, exp_data);
    check("postrst_busy", busy, 0);
    $display("reset mid-read data=%h", bridge_rd_data);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
